mmul_tile_scheduler: RTL and testbench
======================================

MMUL_TILE_SCHEDULER -- requirements
Module: mmul_tile_scheduler

Interface
REQ-001 Parameter: SYS_ARRAY_SIZE, default from common_pkg, array dimension N; SHALL be >= 2.
REQ-002 Parameter: ADDR_WIDTH, default from common_pkg, byte address width.
REQ-003 Parameter: ROW_BYTES, default from common_pkg, bytes per memory row; CHUNK = SYS_ARRAY_SIZE*ROW_BYTES.
REQ-004 Parameter: CNT_WIDTH, default 8, width of tile/chunk counts.
REQ-005 clk_i  in  1  single clock; all state on rising edge.
REQ-006 rst_i  in  1  reset, asynchronous, active-high.
REQ-007 start_i  in  1  start job; sampled only in IDLE.
REQ-008 base_a_i, base_b_i  in  ADDR_WIDTH  operand A/B base byte addresses.
REQ-009 m_tiles_i, n_tiles_i, k_chunks_i  in  CNT_WIDTH  output tile rows, tile cols, reduction chunks.
REQ-010 wb_done_i  in  1  one-cycle pulse: write-back of current output tile complete.
REQ-011 cmd_valid_o  out  1  one-cycle read command pulse to read data handler.
REQ-012 cmd_addr_a_o, cmd_addr_b_o  out  ADDR_WIDTH  command start addresses.
REQ-013 cmd_we_o  out  1  final chunk of tile (handler emits last).
REQ-014 tile_row_o, tile_col_o  out  CNT_WIDTH  indices of tile in flight.
REQ-015 busy_o  out  1  job active; done_o  out  1  one-cycle job-complete pulse.

Function
REQ-016 States: IDLE, ISSUE, GAP, WAIT_WB, DONE.
REQ-017 IDLE + start_i: latch bases and counts, clear i/j/k, addr_a=a_row=base_a_i, addr_b=base_b_i; go ISSUE, or DONE if any count is 0.
REQ-018 start_i outside IDLE SHALL be ignored.
REQ-019 ISSUE (exactly one cycle): cmd_valid_o=1, addresses = addr_a/addr_b, cmd_we_o=(k==k_chunks-1); go GAP.
REQ-020 GAP: SYS_ARRAY_SIZE-1 cycles; successive cmd_valid_o pulses are exactly SYS_ARRAY_SIZE cycles apart.
REQ-021 After GAP, non-final chunk: k+=1, addr_a+=CHUNK, addr_b+=CHUNK, go ISSUE.
REQ-022 After GAP, final chunk: go WAIT_WB (or skip to tile advance if wb pending flag set).
REQ-023 wb_done_i in GAP after a final-chunk issue or in WAIT_WB SHALL set/consume a pending flag; wb_done_i at any other time ignored.
REQ-024 Tile advance: k=0; if j<n_tiles-1: j+=1, addr_a=a_row, addr_b+=CHUNK; else j=0, i+=1, a_row=addr_a+CHUNK, addr_a=a_row, addr_b=base_b; go ISSUE; if last tile (i=m_tiles-1, j=n_tiles-1) go DONE.
REQ-025 Resulting address: A = base_a+(i*K+k)*CHUNK, B = base_b+(j*K+k)*CHUNK; arithmetic modulo 2^ADDR_WIDTH (wrap, no flag).
REQ-026 DONE: one cycle, done_o=1, busy_o=0, go IDLE.
REQ-027 busy_o=1 in ISSUE, GAP, WAIT_WB; 0 in IDLE, DONE.
REQ-028 tile_row_o/tile_col_o = i/j, stable from first issue of a tile until tile advance.
REQ-029 cmd_addr_*_o, cmd_we_o SHALL be 0 when cmd_valid_o=0.
REQ-030 Latency: start_i at cycle 0 -> first cmd_valid_o at cycle 1.

Reset
REQ-031 rst_i asserted: immediately IDLE; cmd_valid_o, cmd_we_o, busy_o, done_o, addresses, counters, indices, pending flag = 0.
REQ-032 Reset mid-job SHALL abandon the job with no further commands; new start_i accepted first cycle after release.

Verification
REQ-033 N=4, ROW_BYTES=16, base_a=0x100, base_b=0x800, m=n=k=1 -> one pulse at cycle 1, A=0x100, B=0x800, we=1; wb_done at cycle 10 -> done_o cycle 11.
REQ-034 m=1,n=1,k=3 -> pulses cycles 1,5,9; A=0x100,0x140,0x180; B=0x800,0x840,0x880; we only on third.
REQ-035 m=2,n=2,k=2 -> A sequence per tile: (0,0) 0x100,0x140; (0,1) 0x100,0x140; (1,0) 0x180,0x1C0; B for col1 0x880,0x8C0; tile_row/col track.
REQ-036 k=0 with start -> no cmd_valid_o, done_o next cycle; start_i while busy -> no effect.
REQ-037 wb_done_i during GAP of final chunk -> next tile ISSUE immediately after GAP; stray wb_done_i during non-final GAP ignored.
REQ-038 rst_i asserted in GAP of m=n=k=2 job -> outputs 0 same cycle, no further pulses; fresh start after release behaves as REQ-033.

Source files
------------

// File: rtl/mmul_tile_scheduler.sv
// Matrix-multiply tile scheduler: walks output tiles (i, j) and reduction chunks k,
// issuing one read command every SYS_ARRAY_SIZE cycles and pausing for write-back
// after the final chunk of each tile.
// Parameter defaults mirror the shared project configuration (N=4, 16-byte rows).
module mmul_tile_scheduler #(
    parameter int unsigned SYS_ARRAY_SIZE = 4,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned ROW_BYTES      = 16,
    parameter int unsigned CNT_WIDTH      = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_a_i,
    input  logic [ADDR_WIDTH-1:0] base_b_i,
    input  logic [CNT_WIDTH-1:0]  m_tiles_i,
    input  logic [CNT_WIDTH-1:0]  n_tiles_i,
    input  logic [CNT_WIDTH-1:0]  k_chunks_i,
    input  logic                  wb_done_i,
    output logic                  cmd_valid_o,
    output logic [ADDR_WIDTH-1:0] cmd_addr_a_o,
    output logic [ADDR_WIDTH-1:0] cmd_addr_b_o,
    output logic                  cmd_we_o,
    output logic [CNT_WIDTH-1:0]  tile_row_o,
    output logic [CNT_WIDTH-1:0]  tile_col_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam logic [ADDR_WIDTH-1:0] CHUNK    = ADDR_WIDTH'(SYS_ARRAY_SIZE * ROW_BYTES);
    localparam int unsigned           GW       = $clog2(SYS_ARRAY_SIZE);
    // Gap lasts SYS_ARRAY_SIZE-1 cycles, counted 0 .. N-2.
    localparam logic [GW-1:0]         GAP_LAST = GW'(SYS_ARRAY_SIZE - 2);
    localparam logic [CNT_WIDTH-1:0]  ONE      = CNT_WIDTH'(1);

    typedef enum logic [2:0] {StIdle, StIssue, StGap, StWaitWb, StDone} state_e;

    state_e                state_q, state_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic [CNT_WIDTH-1:0]  i_q, i_d, j_q, j_d, k_q, k_d;
    logic [CNT_WIDTH-1:0]  m_q, m_d, n_q, n_d, kc_q, kc_d;
    logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    logic [ADDR_WIDTH-1:0] a_row_q, a_row_d, base_b_q, base_b_d;
    logic                  pend_q, pend_d;
    logic                  last_k, last_tile, adv;

    assign last_k    = (k_q == kc_q - ONE);
    assign last_tile = (i_q == m_q - ONE) && (j_q == n_q - ONE);

    // State and datapath registers; reset abandons any job in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            gap_q    <= '0;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            m_q      <= '0;
            n_q      <= '0;
            kc_q     <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            a_row_q  <= '0;
            base_b_q <= '0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            m_q      <= m_d;
            n_q      <= n_d;
            kc_q     <= kc_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            a_row_q  <= a_row_d;
            base_b_q <= base_b_d;
            pend_q   <= pend_d;
        end
    end

    // Next-state: sequencing, chunk stepping and tile advance.
    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        i_d      = i_q;
        j_d      = j_q;
        k_d      = k_q;
        m_d      = m_q;
        n_d      = n_q;
        kc_d     = kc_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        a_row_d  = a_row_q;
        base_b_d = base_b_q;
        pend_d   = pend_q;
        adv      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    m_d      = m_tiles_i;
                    n_d      = n_tiles_i;
                    kc_d     = k_chunks_i;
                    i_d      = '0;
                    j_d      = '0;
                    k_d      = '0;
                    addr_a_d = base_a_i;
                    a_row_d  = base_a_i;
                    addr_b_d = base_b_i;
                    base_b_d = base_b_i;
                    pend_d   = 1'b0;
                    gap_d    = '0;
                    if (m_tiles_i == '0 || n_tiles_i == '0 || k_chunks_i == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                gap_d   = '0;
                state_d = StGap;
            end
            StGap: begin
                // Early write-back is only meaningful once the final chunk has gone out.
                if (wb_done_i && last_k) begin
                    pend_d = 1'b1;
                end
                if (gap_q == GAP_LAST) begin
                    if (!last_k) begin
                        k_d      = k_q + ONE;
                        addr_a_d = addr_a_q + CHUNK;
                        addr_b_d = addr_b_q + CHUNK;
                        state_d  = StIssue;
                    end else if (pend_q || wb_done_i) begin
                        adv = 1'b1;
                    end else begin
                        state_d = StWaitWb;
                    end
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            StWaitWb: begin
                if (wb_done_i) begin
                    adv = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (adv) begin
            pend_d = 1'b0;
            k_d    = '0;
            if (last_tile) begin
                state_d = StDone;
            end else begin
                state_d = StIssue;
                if (j_q < n_q - ONE) begin
                    j_d      = j_q + ONE;
                    addr_a_d = a_row_q;
                    addr_b_d = addr_b_q + CHUNK;
                end else begin
                    // addr_a already points at the last chunk of this row of A.
                    j_d      = '0;
                    i_d      = i_q + ONE;
                    a_row_d  = addr_a_q + CHUNK;
                    addr_a_d = addr_a_q + CHUNK;
                    addr_b_d = base_b_q;
                end
            end
        end
    end

    // Outputs decoded from state; command fields forced to zero outside ISSUE.
    always_comb begin
        cmd_valid_o  = (state_q == StIssue);
        cmd_addr_a_o = cmd_valid_o ? addr_a_q : '0;
        cmd_addr_b_o = cmd_valid_o ? addr_b_q : '0;
        cmd_we_o     = cmd_valid_o && last_k;
        tile_row_o   = i_q;
        tile_col_o   = j_q;
        busy_o       = (state_q == StIssue) || (state_q == StGap) || (state_q == StWaitWb);
        done_o       = (state_q == StDone);
    end

endmodule

// File: tb/tb_mmul_tile_scheduler.sv
// Self-checking bench for mmul_tile_scheduler: a job-level model lays out the
// expected command timeline, which is then compared cycle by cycle.
module tb_mmul_tile_scheduler;

    localparam int N     = 4;
    localparam int AW    = 16;
    localparam int RB    = 16;
    localparam int CW    = 8;
    localparam int CHUNK = N * RB;
    localparam int MAXC  = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_a, base_b;
    logic [CW-1:0] m_tiles, n_tiles, k_chunks;
    logic          wb_done;
    logic          cmd_valid, cmd_we, busy, done;
    logic [AW-1:0] cmd_a, cmd_b;
    logic [CW-1:0] tile_row, tile_col;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected timeline, indexed by cycle relative to the start cycle.
    bit            ev  [MAXC];
    logic [AW-1:0] ea  [MAXC];
    logic [AW-1:0] eb  [MAXC];
    bit            ewe [MAXC];
    int            erow[MAXC];
    int            ecol[MAXC];
    bit            ewb [MAXC];

    always #5 clk = ~clk;

    mmul_tile_scheduler #(
        .SYS_ARRAY_SIZE(N),
        .ADDR_WIDTH    (AW),
        .ROW_BYTES     (RB),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .base_a_i    (base_a),
        .base_b_i    (base_b),
        .m_tiles_i   (m_tiles),
        .n_tiles_i   (n_tiles),
        .k_chunks_i  (k_chunks),
        .wb_done_i   (wb_done),
        .cmd_valid_o (cmd_valid),
        .cmd_addr_a_o(cmd_a),
        .cmd_addr_b_o(cmd_b),
        .cmd_we_o    (cmd_we),
        .tile_row_o  (tile_row),
        .tile_col_o  (tile_col),
        .busy_o      (busy),
        .done_o      (done)
    );

    // Runs one job starting at the current negedge (cycle 0). fixed_d > 0 puts the
    // write-back pulse that many cycles after each final-chunk issue; 0 randomises it.
    task automatic run_job(input int m, input int n, input int k, input int ba, input int bb,
                           input int fixed_d, input bit strays, input bit busy_start,
                           input string tag);
        int t, tf, w, done_cyc, nxt;
        for (int c = 0; c < MAXC; c++) begin
            ev[c] = 0; ea[c] = '0; eb[c] = '0; ewe[c] = 0;
            erow[c] = 0; ecol[c] = 0; ewb[c] = 0;
        end
        if (m == 0 || n == 0 || k == 0) begin
            done_cyc = 1;
        end else begin
            t = 1;
            for (int i = 0; i < m; i++) begin
                for (int j = 0; j < n; j++) begin
                    for (int kk = 0; kk < k; kk++) begin
                        ev[t + kk * N]   = 1;
                        ea[t + kk * N]   = AW'(ba + (i * k + kk) * CHUNK);
                        eb[t + kk * N]   = AW'(bb + (j * k + kk) * CHUNK);
                        ewe[t + kk * N]  = (kk == k - 1);
                        erow[t + kk * N] = i;
                        ecol[t + kk * N] = j;
                        if (strays && kk != k - 1)
                            ewb[t + kk * N + $urandom_range(1, N - 1)] = 1;
                    end
                    tf = t + (k - 1) * N;
                    w  = tf + ((fixed_d > 0) ? fixed_d : $urandom_range(1, N + 4));
                    ewb[w] = 1;
                    nxt = (tf + N > w + 1) ? tf + N : w + 1;
                    t = nxt;
                end
            end
            done_cyc = t;
        end

        start    = 1'b1;
        base_a   = AW'(ba);
        base_b   = AW'(bb);
        m_tiles  = CW'(m);
        n_tiles  = CW'(n);
        k_chunks = CW'(k);
        wb_done  = 1'b0;
        for (int c = 1; c <= done_cyc + 2; c++) begin
            @(negedge clk);
            start   = (busy_start && c == 2);
            wb_done = ewb[c];
            if (busy_start && c == 2) begin
                base_a = AW'($urandom); base_b = AW'($urandom);
                m_tiles = CW'(3); n_tiles = CW'(3); k_chunks = CW'(3);
            end
            n_checks++;
            if (cmd_valid !== ev[c]) begin
                n_fail++;
                $display("FAIL %s valid cyc=%0d got=%b exp=%b", tag, c, cmd_valid, ev[c]);
            end
            if (ev[c]) begin
                n_checks++;
                if (cmd_a !== ea[c] || cmd_b !== eb[c] || cmd_we !== ewe[c]) begin
                    n_fail++;
                    $display("FAIL %s cmd cyc=%0d got a=%h b=%h we=%b exp a=%h b=%h we=%b",
                             tag, c, cmd_a, cmd_b, cmd_we, ea[c], eb[c], ewe[c]);
                end
                n_checks++;
                if (tile_row !== CW'(erow[c]) || tile_col !== CW'(ecol[c])) begin
                    n_fail++;
                    $display("FAIL %s tile cyc=%0d got=%0d,%0d exp=%0d,%0d",
                             tag, c, tile_row, tile_col, erow[c], ecol[c]);
                end
            end else begin
                n_checks++;
                if (cmd_a !== '0 || cmd_b !== '0 || cmd_we !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s idle_cmd cyc=%0d got a=%h b=%h we=%b exp zero",
                             tag, c, cmd_a, cmd_b, cmd_we);
                end
            end
            n_checks++;
            if (busy !== (c < done_cyc) || done !== (c == done_cyc)) begin
                n_fail++;
                $display("FAIL %s status cyc=%0d got busy=%b done=%b exp busy=%b done=%b",
                         tag, c, busy, done, (c < done_cyc), (c == done_cyc));
            end
        end
        start   = 1'b0;
        wb_done = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({cmd_valid, cmd_we, busy, done} !== 4'b0 || cmd_a !== '0 || cmd_b !== '0 ||
            tile_row !== '0 || tile_col !== '0) begin
            n_fail++;
            $display("FAIL reset got v=%b we=%b busy=%b done=%b a=%h b=%h exp all zero",
                     cmd_valid, cmd_we, busy, done, cmd_a, cmd_b);
        end
    endtask

    task automatic test_single();
        run_job(1, 1, 1, 'h100, 'h800, 9, 0, 0, "single");
    endtask

    task automatic test_chunks();
        run_job(1, 1, 3, 'h100, 'h800, 0, 0, 0, "k3");
    endtask

    task automatic test_tiles();
        run_job(2, 2, 2, 'h100, 'h800, 0, 0, 0, "m2n2k2");
    endtask

    task automatic test_zero_count();
        run_job(2, 2, 0, 'h100, 'h800, 0, 0, 0, "k0");
        run_job(0, 3, 1, 'h100, 'h800, 0, 0, 0, "m0");
    endtask

    task automatic test_wb_in_gap();
        run_job(2, 2, 2, 'h300, 'h900, 1, 1, 0, "wb_gap");
        run_job(1, 3, 3, 'h040, 'h0C0, N - 1, 1, 0, "wb_gap_last");
    endtask

    task automatic test_start_while_busy();
        run_job(1, 2, 2, 'h100, 'h800, 0, 0, 1, "busy_start");
    endtask

    task automatic test_reset_mid_job();
        start = 1'b1; base_a = 'h100; base_b = 'h800;
        m_tiles = 2; n_tiles = 2; k_chunks = 2; wb_done = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || cmd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid pre got busy=%b v=%b exp busy=1 v=0", busy, cmd_valid);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({cmd_valid, cmd_we, busy, done} !== 4'b0 || cmd_a !== '0 || cmd_b !== '0) begin
            n_fail++;
            $display("FAIL rst_mid async got v=%b we=%b busy=%b done=%b exp zero",
                     cmd_valid, cmd_we, busy, done);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_checks++;
            if (cmd_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid hold cyc=%0d got v=%b busy=%b exp 0", c, cmd_valid, busy);
            end
        end
        rst = 1'b0;
        run_job(1, 1, 1, 'h100, 'h800, 9, 0, 0, "after_rst");
    endtask

    task automatic test_random();
        for (int r = 0; r < 20; r++) begin
            run_job($urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 3),
                    int'($urandom_range(0, 'hFFFF)), int'($urandom_range(0, 'hFFFF)),
                    0, $urandom_range(0, 1), $urandom_range(0, 1), "random");
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; wb_done = 1'b0;
        base_a = '0; base_b = '0; m_tiles = '0; n_tiles = '0; k_chunks = '0;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_single();
        test_chunks();
        test_tiles();
        test_zero_count();
        test_wb_in_gap();
        test_start_while_busy();
        test_reset_mid_job();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
